// File: rtl/vga_bounce_box.sv
// Pixel colour source for the VGA sync stage: a square sprite that bounces around the active area.
// Define VGA_BOUNCE_BORDER_EN to draw a white one-pixel frame around the active area.
module vga_bounce_box #(
  parameter int          H_ACTIVE  = 800,
  parameter int          V_ACTIVE  = 600,
  parameter int          BOX_SIZE  = 32,
  parameter logic [23:0] BOX_COLOR = 24'hFF4000,
  parameter logic [23:0] BG_COLOR  = 24'h000040
) (
  input  logic        CLOCK_50,
  input  logic        rst,
  input  logic [11:0] Hpos,
  input  logic [11:0] Vpos,
  input  logic        pause,
  input  logic [1:0]  step_sel,
  output logic [7:0]  R,
  output logic [7:0]  G,
  output logic [7:0]  B,
  output logic [11:0] box_x,
  output logic [11:0] box_y,
  output logic        frame_tick,
  output logic        corner_hit,
  output logic [15:0] bounce_count
);

  typedef enum logic {DIR_FWD, DIR_BACK} dir_t;

  localparam logic [11:0] H_END = 12'(H_ACTIVE);
  localparam logic [11:0] V_END = 12'(V_ACTIVE);
  localparam logic [11:0] X_MAX = 12'(H_ACTIVE - BOX_SIZE);
  localparam logic [11:0] Y_MAX = 12'(V_ACTIVE - BOX_SIZE);
  localparam logic [12:0] SIZE13 = 13'(BOX_SIZE);

  dir_t        dir_x, dir_y;
  dir_t        next_dir_x, next_dir_y;
  logic [11:0] next_x, next_y;
  logic        x_bounce, y_bounce;
  logic [12:0] step;
  logic [12:0] x13, y13, h13, v13;
  logic        do_update;

  assign x13 = {1'b0, box_x};
  assign y13 = {1'b0, box_y};
  assign h13 = {1'b0, Hpos};
  assign v13 = {1'b0, Vpos};
  assign do_update = frame_tick && !pause;

  always_comb begin
    step = 13'd1;
    case (step_sel)
      2'd0: step = 13'd1;
      2'd1: step = 13'd2;
      2'd2: step = 13'd4;
      2'd3: step = 13'd8;
      default: step = 13'd1;
    endcase
  end

  // Both axes use 13-bit sums so box+step can never wrap past the limit
  always_comb begin
    next_x     = box_x;
    next_dir_x = dir_x;
    x_bounce   = 1'b0;
    if (dir_x == DIR_FWD) begin
      if (x13 + step >= {1'b0, X_MAX}) begin
        next_x     = X_MAX;
        next_dir_x = DIR_BACK;
        x_bounce   = 1'b1;
      end else begin
        next_x = box_x + step[11:0];
      end
    end else begin
      if (x13 <= step) begin
        next_x     = '0;
        next_dir_x = DIR_FWD;
        x_bounce   = 1'b1;
      end else begin
        next_x = box_x - step[11:0];
      end
    end
  end

  always_comb begin
    next_y     = box_y;
    next_dir_y = dir_y;
    y_bounce   = 1'b0;
    if (dir_y == DIR_FWD) begin
      if (y13 + step >= {1'b0, Y_MAX}) begin
        next_y     = Y_MAX;
        next_dir_y = DIR_BACK;
        y_bounce   = 1'b1;
      end else begin
        next_y = box_y + step[11:0];
      end
    end else begin
      if (y13 <= step) begin
        next_y     = '0;
        next_dir_y = DIR_FWD;
        y_bounce   = 1'b1;
      end else begin
        next_y = box_y - step[11:0];
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      box_x        <= '0;
      box_y        <= '0;
      dir_x        <= DIR_FWD;
      dir_y        <= DIR_FWD;
      frame_tick   <= 1'b0;
      corner_hit   <= 1'b0;
      bounce_count <= '0;
    end else begin
      frame_tick <= (Hpos == H_END) && (Vpos == V_END);
      corner_hit <= 1'b0;
      if (do_update) begin
        box_x      <= next_x;
        box_y      <= next_y;
        dir_x      <= next_dir_x;
        dir_y      <= next_dir_y;
        corner_hit <= x_bounce && y_bounce;
        if ((x_bounce || y_bounce) && (bounce_count != 16'hFFFF))
          bounce_count <= bounce_count + 16'd1;
      end
    end
  end

  logic sprite_hit;
  logic on_border;
  logic [23:0] rgb;

  assign sprite_hit = (h13 >= x13) && (h13 < x13 + SIZE13) &&
                      (v13 >= y13) && (v13 < y13 + SIZE13);

`ifdef VGA_BOUNCE_BORDER_EN
  assign on_border = (Hpos < H_END) && (Vpos < V_END) &&
                     ((Hpos == 12'd0) || (Hpos == H_END - 12'd1) ||
                      (Vpos == 12'd0) || (Vpos == V_END - 12'd1));
`else
  assign on_border = 1'b0;
`endif

  always_comb begin
    rgb = BG_COLOR;
    if (sprite_hit) rgb = BOX_COLOR;
    if (on_border)  rgb = 24'hFFFFFF;
  end

  assign R = rgb[23:16];
  assign G = rgb[15:8];
  assign B = rgb[7:0];

endmodule

// File: tb/tb_vga_bounce_box.sv
// Directed bench for vga_bounce_box: frames are synthesised by parking Hpos/Vpos on (800,600).
// Honours VGA_BOUNCE_BORDER_EN for the border pixel expectations.
module tb_vga_bounce_box;

  logic        CLOCK_50 = 1'b0;
  logic        rst;
  logic [11:0] Hpos, Vpos;
  logic        pause;
  logic [1:0]  step_sel;
  logic [7:0]  R, G, B;
  logic [11:0] box_x, box_y;
  logic        frame_tick, corner_hit;
  logic [15:0] bounce_count;

  int total = 0;
  int bad   = 0;
  int ticks = 0;
  int wide  = 0;
  logic prev_tick = 1'b0;

  localparam logic [23:0] BOX = 24'hFF4000;
  localparam logic [23:0] BG  = 24'h000040;
  localparam logic [23:0] WHT = 24'hFFFFFF;

  always #5 CLOCK_50 = ~CLOCK_50;

  vga_bounce_box dut (
    .CLOCK_50    (CLOCK_50),
    .rst         (rst),
    .Hpos        (Hpos),
    .Vpos        (Vpos),
    .pause       (pause),
    .step_sel    (step_sel),
    .R           (R),
    .G           (G),
    .B           (B),
    .box_x       (box_x),
    .box_y       (box_y),
    .frame_tick  (frame_tick),
    .corner_hit  (corner_hit),
    .bounce_count(bounce_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and sample 1 ns after the edge; tallies frame_tick pulses and widths
  task automatic cyc();
    @(posedge CLOCK_50);
    #1;
    if (frame_tick === 1'b1) begin
      ticks++;
      if (prev_tick === 1'b1) wide++;
    end
    prev_tick = frame_tick;
  endtask

  // End-of-frame pixel, then one blank pixel; the update lands on the second edge
  task automatic frame();
    Hpos = 12'd800; Vpos = 12'd600;
    cyc();
    Hpos = 12'd801;
    cyc();
  endtask

  task automatic pix(input string tag, input int h, input int v, input logic [23:0] exp);
    Hpos = 12'(h); Vpos = 12'(v);
    #1;
    chk(tag, {8'h00, R, G, B}, {8'h00, exp});
  endtask

  task automatic pos(input string tag, input int x, input int y, input int cnt);
    chk({tag, "_x"}, 32'(box_x), 32'(x));
    chk({tag, "_y"}, 32'(box_y), 32'(y));
    chk({tag, "_cnt"}, 32'(bounce_count), 32'(cnt));
  endtask

  initial begin
    rst = 1'b1; Hpos = '0; Vpos = '0; pause = 1'b0; step_sel = 2'd0;
    cyc();
    cyc();
    pos("reset", 0, 0, 0);
    chk("reset_tick", 32'(frame_tick), 0);
    chk("reset_corner", 32'(corner_hit), 0);
    rst = 1'b0;

    pix("pix_10_10", 10, 10, BOX);
    pix("pix_40_40", 40, 40, BG);
    pix("pix_31_31", 31, 31, BOX);
    pix("pix_32_31", 32, 31, BG);
    pix("pix_31_32", 31, 32, BG);
`ifdef VGA_BOUNCE_BORDER_EN
    pix("pix_0_300", 0, 300, WHT);
    pix("pix_0_10", 0, 10, WHT);
    pix("pix_799_599", 799, 599, WHT);
    pix("pix_800_599", 800, 599, BG);
`else
    pix("pix_0_300", 0, 300, BG);
    pix("pix_0_10", 0, 10, BOX);
    pix("pix_799_599", 799, 599, BG);
`endif

    // Step 4 for three frames, checking that active pixels never move the sprite
    step_sel = 2'd2;
    ticks = 0;
    frame();
    pos("f1", 4, 4, 0);
    Hpos = 12'd5; Vpos = 12'd5;
    repeat (3) cyc();
    Hpos = 12'd799; Vpos = 12'd599;
    cyc();
    Hpos = 12'd800; Vpos = 12'd599;
    cyc();
    cyc();
    pos("active_hold", 4, 4, 0);
    frame();
    frame();
    pos("f3", 12, 12, 0);
    chk("tick_count3", 32'(ticks), 3);

    // 188 more frames: y bounces once at 568, x ends on 764
    repeat (188) frame();
    pos("pre_edge", 764, 372, 1);
    step_sel = 2'd3;
    frame();
    pos("x_bounce", 768, 364, 2);
    chk("x_bounce_corner", 32'(corner_hit), 0);
    frame();
    pos("x_after", 760, 356, 2);
    pix("pix_box_tl", 760, 356, BOX);
    pix("pix_box_br", 791, 387, BOX);
    pix("pix_right_out", 792, 356, BG);
    pix("pix_left_out", 759, 356, BG);
    pix("pix_below_out", 760, 388, BG);

    pause = 1'b1;
    ticks = 0;
    repeat (5) frame();
    chk("pause_ticks", 32'(ticks), 5);
    pos("pause_hold", 760, 356, 2);
    pause = 1'b0;

    Hpos = 12'd100; Vpos = 12'd50;
    rst = 1'b1;
    cyc();
    pos("mid_rst", 0, 0, 0);
    pix("mid_rst_pix", 10, 10, BOX);

    // A frame end seen while rst is high must not produce an update afterwards
    Hpos = 12'd800; Vpos = 12'd600;
    cyc();
    chk("rst_tick_drop", 32'(frame_tick), 0);
    rst = 1'b0;
    Hpos = 12'd801;
    cyc();
    cyc();
    pos("rst_no_update", 0, 0, 0);

    // Step 8: x period 192 updates, y period 142; first shared bounce is update 6816 at (768,0)
    step_sel = 2'd3;
    repeat (6815) frame();
    pos("pre_corner", 760, 8, 165);
    chk("pre_corner_hit", 32'(corner_hit), 0);
    frame();
    chk("corner_hit", 32'(corner_hit), 1);
    pos("corner", 768, 0, 166);
    cyc();
    chk("corner_width", 32'(corner_hit), 0);
    frame();
    pos("post_corner", 760, 8, 166);

    chk("tick_width", 32'(wide), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_bounce_box.md
Name: vga_bounce_box

Overview:
- Pixel-colour generator that sits directly upstream of the VGA sync/timing stage.
- It consumes that stage's Hpos/Vpos counters and returns R/G/B for the current pixel with zero latency, so colour stays aligned with HS/VS.
- It holds a square sprite that moves once per frame at a selectable speed and bounces off the edges of the 800x600 active area.
- It also counts bounces and reports corner hits.

Parameters:
- H_ACTIVE, 800, visible pixels per line.
- V_ACTIVE, 600, visible lines per frame.
- BOX_SIZE, 32, sprite edge length in pixels; must be less than both H_ACTIVE and V_ACTIVE.
- BOX_COLOR, 24'hFF4000, sprite RGB as {R,G,B}.
- BG_COLOR, 24'h000040, background RGB as {R,G,B}.

Ports:
- CLOCK_50  in  1  pixel clock, shared with the sync stage.
- rst  in  1  synchronous reset, active-high.
- Hpos  in  12  current horizontal pixel index from the sync stage.
- Vpos  in  12  current line index from the sync stage.
- pause  in  1  1 = hold sprite position and direction.
- step_sel  in  2  pixels moved per frame: 0->1, 1->2, 2->4, 3->8.
- R  out  8  red for pixel (Hpos,Vpos).
- G  out  8  green for pixel (Hpos,Vpos).
- B  out  8  blue for pixel (Hpos,Vpos).
- box_x  out  12  sprite left column (registered).
- box_y  out  12  sprite top line (registered).
- frame_tick  out  1  one-cycle pulse, once per frame.
- corner_hit  out  1  one-cycle pulse, on an update that bounces on both axes.
- bounce_count  out  16  saturating count of update cycles that contained at least one bounce.

Behaviour:
- Clock and reset: one clock, CLOCK_50. rst is synchronous and active-high; all state clears on the first CLOCK_50 edge where rst=1.
- Reset values:
  - box_x=0, box_y=0.
  - dir_x=right, dir_y=down.
  - frame_tick=0, corner_hit=0, bounce_count=0.
- Colour path (combinational from Hpos/Vpos and registered state):
  - Sprite hit = box_x <= Hpos < box_x+BOX_SIZE and box_y <= Vpos < box_y+BOX_SIZE.
  - Sprite hit -> BOX_COLOR. Otherwise -> BG_COLOR.
  - Blanking outside the active area is done downstream; this block colours every Hpos/Vpos.
- Frame detect:
  - frame_tick is registered and asserts the cycle after Hpos==H_ACTIVE && Vpos==V_ACTIVE.
  - This is the first blank pixel after the last active line, so exactly one pulse per frame. Position never changes while active pixels are drawn.
- Update, in the cycle frame_tick=1, when pause=0. Let s = step from step_sel, sampled in that same cycle. X axis:
  - Moving right, box_x+s >= H_ACTIVE-BOX_SIZE: box_x <= H_ACTIVE-BOX_SIZE, dir_x <= left, x_bounce.
  - Moving right otherwise: box_x <= box_x+s.
  - Moving left, box_x <= s: box_x <= 0, dir_x <= right, x_bounce.
  - Moving left otherwise: box_x <= box_x-s.
- Y axis: same rules using V_ACTIVE, box_y, dir_y, y_bounce.
- Bounce accounting:
  - x_bounce or y_bounce -> bounce_count +1, saturating at 16'hFFFF. A corner counts once.
  - x_bounce and y_bounce -> corner_hit=1 for that one cycle, registered alongside the position update.
- Pause: pause=1 on the update cycle means no position, direction, count or corner_hit change. frame_tick still pulses.
- Arithmetic: comparisons done at 13 bits to avoid wrap; box_x/box_y never leave [0, ACTIVE-BOX_SIZE].
- Reset mid-frame: state clears on the next edge and the colour output follows immediately. frame_tick raised during the rst cycle is discarded.
- step_sel changes mid-frame take effect only at the next update.

Optional Feature:
- Macro: VGA_BOUNCE_BORDER_EN.
- When defined: pixels with Hpos==0, Hpos==H_ACTIVE-1, Vpos==0 or Vpos==V_ACTIVE-1, inside the active area, output 24'hFFFFFF. The border has priority over the sprite.
- When undefined: no border logic; colour is sprite or background only.

Test Plan:
- rst=1 for 2 cycles, then sweep one frame -> box_x=0, box_y=0, bounce_count=0; pixel (10,10)=FF/40/00; pixel (40,40)=00/00/40.
- step_sel=2, pause=0, run 3 frames -> frame_tick pulses 3 times, each 1 cycle wide; box_x=box_y=12 after the third pulse; no change while Hpos<800 && Vpos<600.
- Force start box_x=764 moving right, step_sel=3 -> next update gives box_x=768, dir left, bounce_count+1; following update gives box_x=760.
- Corner: box_x=768, box_y=568, both moving positive, step 1 -> corner_hit one cycle; bounce_count+1, not +2; dirs become left/up.
- pause=1 across 5 frames -> frame_tick pulses 5 times; box_x, box_y, bounce_count unchanged. Assert rst mid-line -> all state 0 on the next edge.
- With VGA_BOUNCE_BORDER_EN: pixel (0,300) and (799,599) = FF/FF/FF even under the sprite at (0,0). Without it: pixel (0,300)=00/00/40.
